univ_shift_reg_n: RTL and testbench

Parametrised universal shift register, the successor to the 4-bit parallel-load register. It provides hold, logical shift in both directions, rotate, parallel load and synchronous clear. It also has a self-timed burst mode that shifts the word a programmed number of positions, with a busy/done handshake. It sits between parallel datapath registers and serial links (serializer/deserializer front end).

---
 rtl/univ_shift_reg_n_if.sv | 31 +++
 rtl/univ_shift_reg_n.sv | 82 ++++++++
 tb/tb_univ_shift_reg_n.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_n_if.sv
// Bus bundle for the universal shift register.
// The master drives control, load data and serial inputs; the slave returns register state.
interface univ_shift_reg_n_if #(
    parameter int word_size = 8,
    parameter int len_w     = $clog2(word_size + 1)
);
    logic [2:0]           mode;
    logic [word_size-1:0] Data_in;
    logic                 sin_msb;
    logic                 sin_lsb;
    logic                 start;
    logic                 burst_dir;
    logic [len_w-1:0]     burst_len;
    logic [word_size-1:0] Data_out;
    logic                 sout_lsb;
    logic                 sout_msb;
    logic                 busy;
    logic                 done;

    modport master (
        output mode, Data_in, sin_msb, sin_lsb,
        output start, burst_dir, burst_len,
        input  Data_out, sout_lsb, sout_msb, busy, done
    );

    modport slave (
        input  mode, Data_in, sin_msb, sin_lsb,
        input  start, burst_dir, burst_len,
        output Data_out, sout_lsb, sout_msb, busy, done
    );
endinterface

// File: rtl/univ_shift_reg_n.sv
// Universal shift register: hold/shift/rotate/load/clear per cycle,
// plus a self-timed burst that shifts a programmed number of places.
module univ_shift_reg_n #(
    parameter int word_size = 8,
    parameter int len_w     = $clog2(word_size + 1)
) (
    input logic               clock,
    input logic               reset,
    univ_shift_reg_n_if.slave bus
);
    localparam int CW = $clog2(word_size + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic                 dir;
    logic                 done_q;
    logic [word_size-1:0] q;
    logic [word_size-1:0] shr;
    logic [word_size-1:0] shl;
    logic [word_size-1:0] rotr;
    logic [word_size-1:0] rotl;
    logic [CW-1:0]        len_sat;

    assign shr  = {bus.sin_msb, q[word_size-1:1]};
    assign shl  = {q[word_size-2:0], bus.sin_lsb};
    assign rotr = {q[0], q[word_size-1:1]};
    assign rotl = {q[word_size-2:0], q[word_size-1]};

    // Longer requests saturate at one full word of shifting
    assign len_sat = (int'(bus.burst_len) > word_size) ?
                     CW'(word_size) : CW'(bus.burst_len);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            dir    <= 1'b0;
            done_q <= 1'b0;
            q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.burst_len != '0) begin
                            state <= SHIFT;
                            dir   <= bus.burst_dir;
                            count <= len_sat;
                        end
                    end else begin
                        case (bus.mode)
                            3'b001:  q <= shr;
                            3'b010:  q <= shl;
                            3'b011:  q <= bus.Data_in;
                            3'b100:  q <= rotr;
                            3'b101:  q <= rotl;
                            3'b110:  q <= '0;
                            default: q <= q;
                        endcase
                    end
                end
                SHIFT: begin
                    q     <= dir ? shl : shr;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Data_out = q;
    assign bus.sout_lsb = q[0];
    assign bus.sout_msb = q[word_size-1];
    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n at widths 4, 8 and 16.
// Expected words are hand-computed per step.
module tb_univ_shift_reg_n;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    univ_shift_reg_n_if #(.word_size(4))  b4 ();
    univ_shift_reg_n_if #(.word_size(8))  b8 ();
    univ_shift_reg_n_if #(.word_size(16)) b16 ();

    univ_shift_reg_n #(.word_size(4))  u4  (.clock(clock), .reset(reset), .bus(b4));
    univ_shift_reg_n #(.word_size(8))  u8  (.clock(clock), .reset(reset), .bus(b8));
    univ_shift_reg_n #(.word_size(16)) u16 (.clock(clock), .reset(reset), .bus(b16));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input int w, input logic [2:0] m,
                       input logic [31:0] d, input logic sm,
                       input logic sl, input logic st,
                       input logic dr, input logic [4:0] ln);
        case (w)
            4: begin
                b4.mode = m; b4.Data_in = d[3:0];
                b4.sin_msb = sm; b4.sin_lsb = sl;
                b4.start = st; b4.burst_dir = dr;
                b4.burst_len = ln[2:0];
            end
            8: begin
                b8.mode = m; b8.Data_in = d[7:0];
                b8.sin_msb = sm; b8.sin_lsb = sl;
                b8.start = st; b8.burst_dir = dr;
                b8.burst_len = ln[3:0];
            end
            default: begin
                b16.mode = m; b16.Data_in = d[15:0];
                b16.sin_msb = sm; b16.sin_lsb = sl;
                b16.start = st; b16.burst_dir = dr;
                b16.burst_len = ln[4:0];
            end
        endcase
    endtask

    task automatic see(input int w, input string tag,
                       input logic [31:0] exp, input logic eb,
                       input logic ed);
        logic [31:0] q;
        logic lo, hi, bz, dn;
        case (w)
            4: begin
                q = 32'(b4.Data_out); lo = b4.sout_lsb;
                hi = b4.sout_msb; bz = b4.busy; dn = b4.done;
            end
            8: begin
                q = 32'(b8.Data_out); lo = b8.sout_lsb;
                hi = b8.sout_msb; bz = b8.busy; dn = b8.done;
            end
            default: begin
                q = 32'(b16.Data_out); lo = b16.sout_lsb;
                hi = b16.sout_msb; bz = b16.busy; dn = b16.done;
            end
        endcase
        chk($sformatf("w%0d %s data", w, tag), q, exp);
        chk($sformatf("w%0d %s sout_lsb", w, tag), 32'(lo), 32'(exp[0]));
        chk($sformatf("w%0d %s sout_msb", w, tag), 32'(hi), 32'(exp[w-1]));
        chk($sformatf("w%0d %s busy", w, tag), 32'(bz), 32'(eb));
        chk($sformatf("w%0d %s done", w, tag), 32'(dn), 32'(ed));
    endtask

    // Shift/rotate sequence from din, then a right burst of 3 from bd
    task automatic run_sr(input int w, input logic [31:0] din,
                          input logic [31:0] e_sr, input logic [31:0] e_sl,
                          input logic [31:0] e_rr, input logic [31:0] e_rl,
                          input logic [31:0] bd, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        drv(w, 3'b011, din, 0, 0, 0, 0, 0); tick; see(w, "ld", din, 0, 0);
        drv(w, 3'b001, 0, 1, 0, 0, 0, 0);   tick; see(w, "sr", e_sr, 0, 0);
        drv(w, 3'b010, 0, 1, 0, 0, 0, 0);   tick; see(w, "sl", e_sl, 0, 0);
        drv(w, 3'b100, 0, 0, 1, 0, 0, 0);   tick; see(w, "rr", e_rr, 0, 0);
        drv(w, 3'b101, 0, 0, 1, 0, 0, 0);   tick; see(w, "rl", e_rl, 0, 0);
        drv(w, 3'b110, 0, 1, 1, 0, 0, 0);   tick; see(w, "clr", 0, 0, 0);
        drv(w, 3'b011, bd, 0, 0, 0, 0, 0);  tick; see(w, "bld", bd, 0, 0);
        drv(w, 3'b011, '1, 0, 0, 1, 0, 3);  tick; see(w, "bk", bd, 1, 0);
        drv(w, 3'b011, '1, 0, 0, 0, 0, 0);  tick; see(w, "b1", e1, 1, 0);
        tick; see(w, "b2", e2, 1, 0);
        tick;
        drv(w, 3'b000, 0, 0, 0, 0, 0, 0);
        see(w, "b3", e3, 0, 1);
        tick; see(w, "b4", e3, 0, 0);
    endtask

    initial begin
        logic [31:0] e;
        drv(4, 0, 0, 0, 0, 0, 0, 0);
        drv(8, 0, 0, 0, 0, 0, 0, 0);
        drv(16, 0, 0, 0, 0, 0, 0, 0);
        #3 reset = 1'b1;
        #1;
        see(4, "rst", 0, 0, 0);
        see(8, "rst", 0, 0, 0);
        see(16, "rst", 0, 0, 0);
        tick;
        reset = 1'b0;

        drv(8, 3'b011, 32'hA5, 0, 0, 0, 0, 0); tick; see(8, "ld", 32'hA5, 0, 0);
        drv(8, 3'b111, 32'h5A, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick; see(8, "rsv", 32'hA5, 0, 0);
        end

        run_sr(8, 32'hA5, 32'hD2, 32'hA4, 32'h52, 32'hA4,
               32'h81, 32'h40, 32'h20, 32'h10);

        drv(8, 3'b011, 32'hFF, 0, 0, 1, 0, 0); tick; see(8, "len0", 32'h10, 0, 0);

        drv(8, 3'b011, 32'h01, 0, 0, 0, 0, 0); tick; see(8, "ld1", 32'h01, 0, 0);
        drv(8, 3'b000, 0, 0, 0, 1, 1, 15);     tick; see(8, "l15k", 32'h01, 1, 0);
        drv(8, 3'b011, 32'hFF, 0, 0, 0, 0, 0);
        e = 32'h01;
        for (int i = 1; i < 8; i++) begin
            tick;
            e = (e << 1) & 32'hFF;
            see(8, "l15s", e, 1, 0);
        end
        tick; see(8, "l15d", 32'h00, 0, 1);

        drv(8, 3'b000, 0, 1, 0, 1, 0, 2); tick; see(8, "b2bk", 32'h00, 1, 0);
        drv(8, 3'b000, 0, 1, 0, 0, 0, 0); tick; see(8, "b2b1", 32'h80, 1, 0);
        tick; see(8, "b2b2", 32'hC0, 0, 1);
        tick; see(8, "b2b3", 32'hC0, 0, 0);

        drv(8, 3'b011, 32'hA5, 0, 0, 0, 0, 0); tick; see(8, "rld", 32'hA5, 0, 0);
        drv(8, 3'b000, 0, 0, 0, 1, 0, 6);      tick; see(8, "rk", 32'hA5, 1, 0);
        drv(8, 3'b000, 0, 0, 0, 0, 0, 0);
        tick; see(8, "rs1", 32'h52, 1, 0);
        tick; see(8, "rs2", 32'h29, 1, 0);
        #2 reset = 1'b1;
        #1 see(8, "rmid", 0, 0, 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick; see(8, "rpost", 0, 0, 0);
        end

        run_sr(4, 32'h5, 32'hA, 32'h4, 32'h2, 32'h4,
               32'h9, 32'h4, 32'h2, 32'h1);
        run_sr(16, 32'hA5A5, 32'hD2D2, 32'hA5A4, 32'h52D2, 32'hA5A4,
               32'h8001, 32'h4000, 32'h2000, 32'h1000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
